// File: rtl/blit_pixser_if.sv
// Handshake/bus bundle between the display DMA fetcher, the video timing side and blit_pixser.
// Source side: pixel_valid is a one-cycle strobe with no back-pressure, so a word offered while the FIFO is full is lost.
interface blit_pixser_if #(
  parameter int DEPTH = 64
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          pixel_valid;
  logic [15:0]   pixel_data;
  logic          vblank;
  logic          de;
  logic          pix_en;
  logic          inv;
  logic          vid_pix;
  logic          vid_valid;
  logic          underrun;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic [15:0]   underrun_cnt;

  modport master (
    output pixel_valid, pixel_data, vblank, de, pix_en, inv,
    input  vid_pix, vid_valid, underrun, overflow, fifo_level, underrun_cnt
  );

  modport slave (
    input  pixel_valid, pixel_data, vblank, de, pix_en, inv,
    output vid_pix, vid_valid, underrun, overflow, fifo_level, underrun_cnt
  );
endinterface

// File: rtl/blit_pixser.sv
// Framebuffer word FIFO plus MSB-first 1-bit pixel serialiser with vblank flush.
// Optional macro BLIT_PIXSER_UNDERRUN_CNT_EN builds a saturating underrun counter.
module blit_pixser #(
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  blit_pixser_if.slave  bus,
  output logic          dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} ser_state_t;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  ser_state_t    state_q, state_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic          vid_pix_q, vid_pix_d;
  logic          vid_valid_q, vid_valid_d;
  logic          underrun_q, underrun_d;

  logic          full, empty, push, pop, consume;
  logic [15:0]   head;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = bus.pixel_valid && !full && !bus.vblank;
  assign consume = bus.pix_en && bus.de && !bus.vblank;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.pixel_data;
  end

  // Flush wins over both push and pop; overflow clears on the same flush.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.vblank) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (!push && pop) count_d = count_q - (AW+1)'(1);
      if (bus.pixel_valid && full) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    pop         = 1'b0;
    vid_pix_d   = vid_pix_q;
    vid_valid_d = 1'b0;
    underrun_d  = 1'b0;
    if (bus.vblank) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
    end else if (consume) begin
      vid_valid_d = 1'b1;
      if (state_q == ST_SHIFT) begin
        vid_pix_d = shreg_q[15] ^ bus.inv;
        if (bitcnt_q != 4'd15) begin
          shreg_d  = {shreg_q[14:0], 1'b0};
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (!empty) begin
          shreg_d  = head;
          pop      = 1'b1;
          bitcnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        // Starved pixel: emit background, but pick up a waiting word for the next one.
        vid_pix_d  = bus.inv;
        underrun_d = 1'b1;
        if (!empty) begin
          shreg_d  = head;
          pop      = 1'b1;
          bitcnt_d = 4'd0;
          state_d  = ST_SHIFT;
        end
      end
    end else if (state_q == ST_IDLE && !empty) begin
      shreg_d  = head;
      pop      = 1'b1;
      bitcnt_d = 4'd0;
      state_d  = ST_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      shreg_q     <= 16'h0;
      bitcnt_q    <= 4'd0;
      vid_pix_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      vid_pix_q   <= vid_pix_d;
      vid_valid_q <= vid_valid_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef BLIT_PIXSER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= 16'h0;
    end else if (underrun_q && ucnt_q != 16'hFFFF) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end
  assign bus.underrun_cnt = ucnt_q;
`else
  assign bus.underrun_cnt = 16'h0;
`endif

  assign bus.vid_pix    = vid_pix_q;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.underrun   = underrun_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = count_q;
  assign dbg_state_o    = (state_q == ST_SHIFT);
endmodule
